// File: rtl/qlearn_pkg.sv
`default_nettype none
// ============================================================================
// Package     : qlearn_pkg
// Description : Shared types and constants for the Q-learning traffic-light
//               agent: Q-value width, action count, Q-row type, and the
//               update-controller FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package qlearn_pkg;

  localparam int Q_W     = 32;
  localparam int NUM_ACT = 4;
  localparam int ACT_W   = 2;

  // One signed Q value and one row of NUM_ACT of them
  typedef logic signed [Q_W-1:0] q_val_t;
  typedef q_val_t [NUM_ACT-1:0]  q_row_t;

  // Update-controller FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BEAT0 = 3'd1,
    ST_BEAT1 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4
  } fsm_state_t;

endpackage : qlearn_pkg
`default_nettype wire

// File: rtl/q_argmax4.sv
`default_nettype none
// ============================================================================
// Module      : q_argmax4
// Description : Combinational signed argmax/max over a 4-entry Q row using a
//               two-level compare tree. Ties resolve to the lowest index, so
//               an all-equal row yields index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module q_argmax4
  import qlearn_pkg::*;
(
  input  q_row_t           row,
  output logic [ACT_W-1:0] idx,
  output logic [Q_W-1:0]   max_val
);

  logic   lo_sel;
  logic   hi_sel;
  logic   top_sel;
  q_val_t lo_max;
  q_val_t hi_max;

  // Pairwise compares, then winner-vs-winner; strict '>' keeps the lower index on ties
  always_comb begin
    lo_sel  = $signed(row[1]) > $signed(row[0]);
    lo_max  = lo_sel ? row[1] : row[0];
    hi_sel  = $signed(row[3]) > $signed(row[2]);
    hi_max  = hi_sel ? row[3] : row[2];
    top_sel = $signed(hi_max) > $signed(lo_max);
    idx     = top_sel ? {1'b1, hi_sel} : {1'b0, lo_sel};
    max_val = top_sel ? hi_max : lo_max;
  end

endmodule : q_argmax4
`default_nettype wire

// File: rtl/q_table_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : q_table_ctrl
// Description : Owns the NUM_STATES x 4 signed Q-table and sequences one
//               Bellman update per accepted (S, A, R, S') tuple: presents
//               row S, then row S' with argmax/A/R, waits QA_LATENCY cycles
//               and writes qa_qnew back to Q[S][A].
// Options     : `define QTBL_POLICY_PORT_EN adds a registered policy read
//               port (pol_state -> pol_action / pol_qmax).
// Revision    : 1.0 - initial release
// ============================================================================
module q_table_ctrl
  import qlearn_pkg::*;
#(
  parameter int NUM_STATES = 16,
  parameter int STATE_W    = 4,
  parameter int QA_LATENCY = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               exp_valid,
  output logic               exp_ready,
  input  logic [STATE_W-1:0] exp_s,
  input  logic [ACT_W-1:0]   exp_a,
  input  logic [Q_W-1:0]     exp_r,
  input  logic [STATE_W-1:0] exp_s_next,
  output logic [Q_W-1:0]     qa_q0,
  output logic [Q_W-1:0]     qa_q1,
  output logic [Q_W-1:0]     qa_q2,
  output logic [Q_W-1:0]     qa_q3,
  output logic [ACT_W-1:0]   qa_a,
  output logic [ACT_W-1:0]   qa_amax,
  output logic [Q_W-1:0]     qa_r,
  input  logic [Q_W-1:0]     qa_qnew,
  output logic               upd_done
`ifdef QTBL_POLICY_PORT_EN
  ,
  input  logic [STATE_W-1:0] pol_state,
  output logic [ACT_W-1:0]   pol_action,
  output logic [Q_W-1:0]     pol_qmax
`endif
);

  // WAIT occupies QA_LATENCY cycles: counter runs 0 .. QA_LATENCY-1
  localparam int               CNT_W    = (QA_LATENCY > 1) ? $clog2(QA_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QA_LATENCY - 1);

  // Indices at or above NUM_STATES address no row
  function automatic logic state_ok(input logic [STATE_W-1:0] st);
    return 32'(st) < NUM_STATES;
  endfunction

  q_row_t tbl_q [NUM_STATES];

  fsm_state_t           state_q,     state_d;
  logic [STATE_W-1:0]   s_q,         s_d;
  logic [STATE_W-1:0]   sn_q,        sn_d;
  logic [ACT_W-1:0]     a_q,         a_d;
  logic [Q_W-1:0]       r_q,         r_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  q_row_t               qa_row_q,    qa_row_d;
  logic [ACT_W-1:0]     qa_a_q,      qa_a_d;
  logic [ACT_W-1:0]     qa_amax_q,   qa_amax_d;
  logic [Q_W-1:0]       qa_r_q,      qa_r_d;
  logic                 upd_done_q,  upd_done_d;
  logic                 exp_ready_q, exp_ready_d;
  logic                 tbl_we;

  q_row_t               row_s;
  q_row_t               row_sn;
  logic [ACT_W-1:0]     amax_idx;
  logic [Q_W-1:0]       amax_val_unused;

  assign row_s  = state_ok(s_q)  ? tbl_q[s_q]  : '0;
  assign row_sn = state_ok(sn_q) ? tbl_q[sn_q] : '0;

  q_argmax4 u_argmax_upd (
    .row     (row_sn),
    .idx     (amax_idx),
    .max_val (amax_val_unused)
  );

  // Next-state and registered-output computation for the update sequencer
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    sn_d        = sn_q;
    a_d         = a_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    qa_row_d    = qa_row_q;
    qa_a_d      = qa_a_q;
    qa_amax_d   = qa_amax_q;
    qa_r_d      = qa_r_q;
    upd_done_d  = 1'b0;
    exp_ready_d = exp_ready_q;
    tbl_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (exp_valid) begin
          s_d         = exp_s;
          a_d         = exp_a;
          r_d         = exp_r;
          sn_d        = exp_s_next;
          exp_ready_d = 1'b0;
          state_d     = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        qa_row_d = row_s;
        state_d  = ST_BEAT1;
      end
      ST_BEAT1: begin
        qa_row_d  = row_sn;
        qa_amax_d = amax_idx;
        qa_a_d    = a_q;
        qa_r_d    = r_q;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          upd_done_d = 1'b1;
          state_d    = ST_WRITE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        // qa_qnew is valid this cycle; out-of-range S suppresses the write
        tbl_we      = state_ok(s_q);
        exp_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        exp_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, latched tuple and registered qa_* outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      s_q         <= '0;
      sn_q        <= '0;
      a_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      qa_row_q    <= '0;
      qa_a_q      <= '0;
      qa_amax_q   <= '0;
      qa_r_q      <= '0;
      upd_done_q  <= 1'b0;
      exp_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      sn_q        <= sn_d;
      a_q         <= a_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      qa_row_q    <= qa_row_d;
      qa_a_q      <= qa_a_d;
      qa_amax_q   <= qa_amax_d;
      qa_r_q      <= qa_r_d;
      upd_done_q  <= upd_done_d;
      exp_ready_q <= exp_ready_d;
    end
  end

  // Q-table storage; reset clears every entry and drops any pending write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STATES; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tbl_q[s_q][a_q] <= qa_qnew;
    end
  end

  assign exp_ready = exp_ready_q;
  assign qa_q0     = qa_row_q[0];
  assign qa_q1     = qa_row_q[1];
  assign qa_q2     = qa_row_q[2];
  assign qa_q3     = qa_row_q[3];
  assign qa_a      = qa_a_q;
  assign qa_amax   = qa_amax_q;
  assign qa_r      = qa_r_q;
  assign upd_done  = upd_done_q;

`ifdef QTBL_POLICY_PORT_EN
  q_row_t           pol_row;
  logic [ACT_W-1:0] pol_action_d, pol_action_q;
  logic [Q_W-1:0]   pol_qmax_d,   pol_qmax_q;

  assign pol_row = state_ok(pol_state) ? tbl_q[pol_state] : '0;

  q_argmax4 u_argmax_pol (
    .row     (pol_row),
    .idx     (pol_action_d),
    .max_val (pol_qmax_d)
  );

  // Policy lookup registered once; reads the table before a same-cycle write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol_action_q <= '0;
      pol_qmax_q   <= '0;
    end else begin
      pol_action_q <= pol_action_d;
      pol_qmax_q   <= pol_qmax_d;
    end
  end

  assign pol_action = pol_action_q;
  assign pol_qmax   = pol_qmax_q;
`endif

endmodule : q_table_ctrl
`default_nettype wire

// File: tb/tb_q_table_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_q_table_ctrl
// Description : Self-checking bench for q_table_ctrl. Holds its own copy of
//               the Q-table, plays the Bellman update stage (Qnew driven only
//               in the write cycle), and checks beat contents, timing, reset
//               and, with QTBL_POLICY_PORT_EN, the policy port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q_table_ctrl;

  localparam int          NS        = 16;
  localparam int          SW        = 4;
  localparam int          LAT       = 5;
  localparam logic [31:0] QNEW_IDLE = 32'h5A5A_5A5A;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          exp_valid = 1'b0;
  logic          exp_ready;
  logic [SW-1:0] exp_s = '0;
  logic [1:0]    exp_a = '0;
  logic [31:0]   exp_r = '0;
  logic [SW-1:0] exp_s_next = '0;
  logic [31:0]   qa_q0, qa_q1, qa_q2, qa_q3;
  logic [1:0]    qa_a, qa_amax;
  logic [31:0]   qa_r;
  logic [31:0]   qa_qnew = QNEW_IDLE;
  logic          upd_done;
`ifdef QTBL_POLICY_PORT_EN
  logic [SW-1:0] pol_state = '0;
  logic [1:0]    pol_action;
  logic [31:0]   pol_qmax;
  bit            pol_chk = 1'b0;
`endif

  q_table_ctrl #(.NUM_STATES(NS), .STATE_W(SW), .QA_LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .exp_valid  (exp_valid),
    .exp_ready  (exp_ready),
    .exp_s      (exp_s),
    .exp_a      (exp_a),
    .exp_r      (exp_r),
    .exp_s_next (exp_s_next),
    .qa_q0      (qa_q0),
    .qa_q1      (qa_q1),
    .qa_q2      (qa_q2),
    .qa_q3      (qa_q3),
    .qa_a       (qa_a),
    .qa_amax    (qa_amax),
    .qa_r       (qa_r),
    .qa_qnew    (qa_qnew),
    .upd_done   (upd_done)
`ifdef QTBL_POLICY_PORT_EN
    ,
    .pol_state  (pol_state),
    .pol_action (pol_action),
    .pol_qmax   (pol_qmax)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference Q-table and bench bookkeeping
  int mdl [NS][4];
  int n_chk  = 0;
  int n_fail = 0;
  int acc_cyc = 0;
  bit ovr_en  = 1'b0;
  int ovr_val = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // First index holding the largest signed value of a row
  function automatic int model_argmax(input int st);
    int best = 0;
    for (int i = 1; i < 4; i++) if (mdl[st][i] > mdl[st][best]) best = i;
    return best;
  endfunction

  task automatic check_row(input string tag, input int row [4]);
    check($sformatf("%s_q0", tag), qa_q0, row[0]);
    check($sformatf("%s_q1", tag), qa_q1, row[1]);
    check($sformatf("%s_q2", tag), qa_q2, row[2]);
    check($sformatf("%s_q3", tag), qa_q3, row[3]);
  endtask

  // Offer one tuple, follow it through both beats, the wait and the write
  task automatic run_tuple(input logic [SW-1:0] s, input logic [1:0] a, input int r,
                           input logic [SW-1:0] sn, input bit hold);
    int row_s [4];
    int row_sn [4];
    int amax, qnew, waited, pol_old;
    for (int i = 0; i < 4; i++) begin
      row_s[i]  = mdl[s][i];
      row_sn[i] = mdl[sn][i];
    end
    amax    = model_argmax(int'(sn));
    pol_old = model_argmax(int'(s));
    if (ovr_en) qnew = ovr_val;
    else qnew = row_s[a] + (((r + row_sn[amax] - row_s[a]) * 3) >>> 2);

    exp_valid = 1'b1; exp_s = s; exp_a = a; exp_r = r; exp_s_next = sn;
    waited = 0;
    while (exp_ready !== 1'b1 && waited < 4 * LAT + 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_wait", 32'(exp_ready), 32'd1);
    @(negedge clk);                       // BEAT0 cycle
    acc_cyc = cyc;
    if (!hold) exp_valid = 1'b0;
    check("busy_ready", 32'(exp_ready), 32'd0);
    @(negedge clk);                       // cycle C: row S
    check_row("beat0", row_s);
    check("c_upd_done", 32'(upd_done), 32'd0);
    @(negedge clk);                       // cycle C+1: row S', amax, A, R
    check_row("beat1", row_sn);
    check("beat1_amax", 32'(qa_amax), 32'(amax));
    check("beat1_a", 32'(qa_a), 32'(a));
    check("beat1_r", qa_r, r);
    for (int k = 2; k <= LAT; k++) begin
      @(negedge clk);                     // cycles C+2 .. C+LAT
      check("wait_upd_done", 32'(upd_done), 32'd0);
      check("wait_ready", 32'(exp_ready), 32'd0);
      check("wait_amax", 32'(qa_amax), 32'(amax));
      check("wait_a", 32'(qa_a), 32'(a));
      check("wait_r", qa_r, r);
    end
    qa_qnew = qnew;
    @(negedge clk);                       // cycle C+1+LAT: write-back
    check("write_upd_done", 32'(upd_done), 32'd1);
    check("write_ready", 32'(exp_ready), 32'd0);
`ifdef QTBL_POLICY_PORT_EN
    if (pol_chk) pol_state = s;
`endif
    @(negedge clk);                       // back in IDLE
    check("idle_upd_done", 32'(upd_done), 32'd0);
    check("idle_ready", 32'(exp_ready), 32'd1);
    qa_qnew = QNEW_IDLE;
    mdl[s][a] = qnew;
`ifdef QTBL_POLICY_PORT_EN
    if (pol_chk) check("pol_old_action", 32'(pol_action), 32'(pol_old));
`endif
  endtask

  task automatic preload(input logic [SW-1:0] s, input logic [1:0] a, input int val);
    ovr_en = 1'b1; ovr_val = val;
    run_tuple(s, a, 0, s, 1'b0);
    ovr_en = 1'b0;
  endtask

  initial begin
    int t0;
    for (int i = 0; i < NS; i++) for (int j = 0; j < 4; j++) mdl[i][j] = 0;

    // Reset and its output values
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_qa_r", qa_r, 32'd0);
    check("rst_qa_a", 32'(qa_a), 32'd0);
    check("rst_qa_amax", 32'(qa_amax), 32'd0);
    check("rst_qa_q0", qa_q0, 32'd0);
    check("rst_upd_done", 32'(upd_done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(exp_ready), 32'd1);

    // First update on an all-zero table, then read row 2 back
    run_tuple(4'd2, 2'd1, 10, 4'd3, 1'b0);
    run_tuple(4'd2, 2'd0, 0, 4'd2, 1'b0);

    // Argmax ties and an all-equal negative row
    preload(4'd3, 2'd0, -5);
    preload(4'd3, 2'd1, 20);
    preload(4'd3, 2'd2, 20);
    preload(4'd3, 2'd3, 4);
    run_tuple(4'd0, 2'd0, 1, 4'd3, 1'b0);
    for (int j = 0; j < 4; j++) preload(4'd4, 2'(j), -1);
    run_tuple(4'd0, 2'd1, 1, 4'd4, 1'b0);

    // S == S': both beats show the pre-update row
    preload(4'd5, 2'd0, 3);
    preload(4'd5, 2'd1, 9);
    preload(4'd5, 2'd2, -2);
    preload(4'd5, 2'd3, 9);
    run_tuple(4'd5, 2'd2, 50, 4'd5, 1'b0);
    run_tuple(4'd6, 2'd0, 0, 4'd5, 1'b0);

    // Valid held across two tuples
    run_tuple(4'd7, 2'd3, -20, 4'd8, 1'b1);
    t0 = acc_cyc;
    run_tuple(4'd8, 2'd0, 5, 4'd7, 1'b0);
    check("b2b_interval", 32'(acc_cyc - t0), 32'(LAT + 4));
    run_tuple(4'd7, 2'd0, 0, 4'd8, 1'b0);

    // Reset asserted in WAIT: update dropped, table cleared
    exp_valid = 1'b1; exp_s = 4'd2; exp_a = 2'd1; exp_r = 33; exp_s_next = 4'd3;
    @(negedge clk);
    exp_valid = 1'b0;
    repeat (3) @(negedge clk);
    qa_qnew = 32'h0000_1234;
    rst_n = 1'b0;
    #1;
    check("mid_rst_qa_r", qa_r, 32'd0);
    check("mid_rst_qa_amax", 32'(qa_amax), 32'd0);
    check("mid_rst_qa_q1", qa_q1, 32'd0);
    check("mid_rst_upd_done", 32'(upd_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NS; i++) for (int j = 0; j < 4; j++) mdl[i][j] = 0;
    @(negedge clk);
    check("mid_rst_ready", 32'(exp_ready), 32'd1);
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      check("mid_rst_no_done", 32'(upd_done), 32'd0);
    end
    qa_qnew = QNEW_IDLE;
    run_tuple(4'd2, 2'd0, 0, 4'd3, 1'b0);

`ifdef QTBL_POLICY_PORT_EN
    // Policy read: old row seen first, written value one cycle later
    pol_chk = 1'b1;
    preload(4'd2, 2'd3, 100);
    pol_chk = 1'b0;
    @(negedge clk);
    check("pol_new_action", 32'(pol_action), 32'd3);
    check("pol_new_qmax", pol_qmax, 32'd100);
`endif

    // Randomized tuples against the reference table
    for (int n = 0; n < 30; n++) begin
      run_tuple(SW'($urandom_range(NS - 1)), 2'($urandom_range(3)),
                int'($urandom_range(200)) - 100, SW'($urandom_range(NS - 1)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_q_table_ctrl
`default_nettype wire
